// File: rtl/core_fault_monitor_pkg.sv
// core_fault_monitor_pkg: APB types, register offsets and STATUS bit indices for the fault monitor
package core_fault_monitor_pkg;
    typedef struct packed {
        logic [31:0] paddr;
        logic [31:0] pwdata;
        logic        pwrite;
        logic        psel;
        logic        penable;
        logic [3:0]  pstrb;
    } apb_req_t;
    typedef struct packed {
        logic [31:0] prdata;
        logic        pready;
        logic        pslverr;
    } apb_resp_t;
    localparam logic [4:0] FaultMonStatusOffset = 5'h00;
    localparam logic [4:0] FaultMonCnt0Offset   = 5'h04;
    localparam logic [4:0] FaultMonCnt1Offset   = 5'h08;
    localparam logic [4:0] FaultMonIrqEnOffset  = 5'h0C;
    localparam logic [4:0] FaultMonThreshOffset = 5'h10;
    localparam int unsigned StatusClass0Bit = 0;
    localparam int unsigned StatusClass1Bit = 1;
    localparam int unsigned StatusAlarmBit  = 2;
endpackage

// File: rtl/core_fault_monitor_if.sv
// core_fault_monitor_if: APB request/response bundle with requester and subordinate views
interface core_fault_monitor_if;
    import core_fault_monitor_pkg::*;
    apb_req_t  req;
    apb_resp_t resp;
    modport master (output req, input resp);
    modport slave (input req, output resp);
endinterface

// File: rtl/core_fault_monitor_fault_event_counter.sv
// core_fault_monitor_fault_event_counter: edge-detected fault class with sticky flag and saturating counter
module core_fault_monitor_fault_event_counter #(
    parameter int unsigned CntWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                fault,
    input  logic                clr_cnt,
    input  logic                clr_sticky,
    output logic [CntWidth-1:0] cnt,
    output logic                sticky
);
    logic fault_q, fault_qq, event_k;
    assign event_k = fault_q & ~fault_qq;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fault_q  <= 1'b0;
            fault_qq <= 1'b0;
            cnt      <= '0;
            sticky   <= 1'b0;
        end else begin
            fault_q  <= fault;
            fault_qq <= fault_q;
            // a clear coinciding with an event leaves exactly that one event counted
            cnt      <= clr_cnt ? CntWidth'(event_k) : (event_k && cnt != '1) ? cnt + 1'b1 : cnt;
            sticky   <= event_k | (sticky & ~clr_sticky);
        end
    end
endmodule

// File: rtl/core_fault_monitor.sv
// core_fault_monitor: turns core fault pulses into sticky flags, counters, irq and alarm behind APB
module core_fault_monitor
    import core_fault_monitor_pkg::*;
#(
    parameter int unsigned CntWidth = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [1:0]         fault_i,
    core_fault_monitor_if.slave apb,
    output logic               irq_o,
    output logic               alarm_o
);
    logic                access, wr, mapped, alarm_q, alarm_set, unused_bits;
    logic [2:0]          idx, irq_en;
    logic [1:0]          sticky, clr_cnt, clr_sticky;
    logic [CntWidth-1:0] cnt [2];
    logic [CntWidth-1:0] thresh;
    logic [31:0]         rdata;
    assign access = apb.req.psel & apb.req.penable;
    assign wr     = access & apb.req.pwrite;
    assign idx    = apb.req.paddr[4:2];
    assign mapped = idx <= FaultMonThreshOffset[4:2];
    assign unused_bits = ^{apb.req.paddr[31:5], apb.req.paddr[1:0], apb.req.pstrb, apb.req.pwdata};
    for (genvar k = 0; k < 2; k++) begin : g_cls
        assign clr_cnt[k]    = wr & (idx == (k == 0 ? FaultMonCnt0Offset[4:2] : FaultMonCnt1Offset[4:2]));
        assign clr_sticky[k] = wr & (idx == FaultMonStatusOffset[4:2]) & apb.req.pwdata[k];
        core_fault_monitor_fault_event_counter #(.CntWidth(CntWidth)) u_cnt (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .fault     (fault_i[k]),
            .clr_cnt   (clr_cnt[k]),
            .clr_sticky(clr_sticky[k]),
            .cnt       (cnt[k]),
            .sticky    (sticky[k])
        );
    end
    assign alarm_set = (thresh != '0) & ((cnt[0] >= thresh) | (cnt[1] >= thresh));
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alarm_q <= 1'b0;
            irq_en  <= '0;
            thresh  <= '0;
        end else begin
            // the live compare outranks software clear, so the alarm cannot be cleared while it still holds
            alarm_q <= alarm_set | (alarm_q & ~(wr & (idx == FaultMonStatusOffset[4:2]) & apb.req.pwdata[StatusAlarmBit]));
            irq_en  <= (wr && idx == FaultMonIrqEnOffset[4:2]) ? apb.req.pwdata[2:0] : irq_en;
            thresh  <= (wr && idx == FaultMonThreshOffset[4:2]) ? apb.req.pwdata[CntWidth-1:0] : thresh;
        end
    end
    always_comb begin
        rdata = idx == FaultMonStatusOffset[4:2] ? {29'd0, alarm_q, sticky[StatusClass1Bit], sticky[StatusClass0Bit]} :
                idx == FaultMonCnt0Offset[4:2]   ? 32'(cnt[0]) :
                idx == FaultMonCnt1Offset[4:2]   ? 32'(cnt[1]) :
                idx == FaultMonIrqEnOffset[4:2]  ? {29'd0, irq_en} :
                idx == FaultMonThreshOffset[4:2] ? 32'(thresh) : 32'd0;
    end
    assign apb.resp = {access ? rdata : 32'd0, 1'b1, access & ~mapped};
    assign irq_o    = |({alarm_q, sticky} & irq_en);
    assign alarm_o  = alarm_q;
endmodule

// File: tb/tb_core_fault_monitor.sv
// tb_core_fault_monitor: directed table and sequence checks of the fault monitor
module tb_core_fault_monitor;
    import core_fault_monitor_pkg::*;
    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
        logic        err;
    } vec_t;
    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic [1:0] fault = 2'b00;
    logic [1:0] fault4 = 2'b00;
    logic       irq, alarm, irq4, alarm4;
    int         errors = 0;
    int         checks = 0;
    core_fault_monitor_if bus();
    core_fault_monitor_if bus4();
    assign bus4.req = bus.req;
    always #5 clk = ~clk;
    core_fault_monitor dut (.clk_i(clk), .rst_ni(rst_ni), .fault_i(fault), .apb(bus), .irq_o(irq), .alarm_o(alarm));
    core_fault_monitor #(.CntWidth(4)) dut4 (.clk_i(clk), .rst_ni(rst_ni), .fault_i(fault4), .apb(bus4), .irq_o(irq4), .alarm_o(alarm4));
    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [1:0] f,
                        output logic [31:0] rd, output logic err, output logic [31:0] rd4);
        @(posedge clk); #1;
        bus.req = '{paddr: a, pwdata: d, pwrite: w, psel: 1'b1, penable: 1'b0, pstrb: 4'hF};
        if (f != 2'b00) fault = f;
        @(posedge clk); #1;
        bus.req.penable = 1'b1;
        if (f != 2'b00) fault = 2'b00;
        #1;
        rd = bus.resp.prdata; err = bus.resp.pslverr; rd4 = bus4.resp.prdata;
        @(posedge clk); #1;
        bus.req = '0;
    endtask
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd, rd4;
        logic        err;
        xfer(1'b1, a, d, 2'b00, rd, err, rd4);
    endtask
    task automatic rd_chk(input string n, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd, rd4;
        logic        err;
        xfer(1'b0, a, 32'd0, 2'b00, rd, err, rd4);
        check(n, rd, exp);
    endtask
    task automatic pulse(input logic [1:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1 fault = f;
            @(posedge clk); #1 fault = 2'b00;
        end
    endtask
    initial begin
        vec_t        tbl [21];
        logic [31:0] rd, rd4;
        logic        err;
        tbl[0]  = '{1'b0, 32'h00, 32'h0, 32'h0, 1'b0};
        tbl[1]  = '{1'b0, 32'h04, 32'h0, 32'h0, 1'b0};
        tbl[2]  = '{1'b0, 32'h08, 32'h0, 32'h0, 1'b0};
        tbl[3]  = '{1'b0, 32'h0C, 32'h0, 32'h0, 1'b0};
        tbl[4]  = '{1'b0, 32'h10, 32'h0, 32'h0, 1'b0};
        tbl[5]  = '{1'b0, 32'h14, 32'h0, 32'h0, 1'b1};
        tbl[6]  = '{1'b1, 32'h0C, 32'h5, 32'h0, 1'b0};
        tbl[7]  = '{1'b0, 32'h0C, 32'h0, 32'h5, 1'b0};
        tbl[8]  = '{1'b1, 32'h0C, 32'hFF, 32'h0, 1'b0};
        tbl[9]  = '{1'b0, 32'h0C, 32'h0, 32'h7, 1'b0};
        tbl[10] = '{1'b1, 32'h10, 32'h1234, 32'h0, 1'b0};
        tbl[11] = '{1'b0, 32'h10, 32'h0, 32'h1234, 1'b0};
        tbl[12] = '{1'b1, 32'h10, 32'hFFFF_ABCD, 32'h0, 1'b0};
        tbl[13] = '{1'b0, 32'h10, 32'h0, 32'hABCD, 1'b0};
        tbl[14] = '{1'b1, 32'h18, 32'hFFFF_FFFF, 32'h0, 1'b1};
        tbl[15] = '{1'b0, 32'h18, 32'h0, 32'h0, 1'b1};
        tbl[16] = '{1'b0, 32'h0C, 32'h0, 32'h7, 1'b0};
        tbl[17] = '{1'b0, 32'h10, 32'h0, 32'hABCD, 1'b0};
        tbl[18] = '{1'b0, 32'h1000_000C, 32'h0, 32'h7, 1'b0};
        tbl[19] = '{1'b1, 32'h0C, 32'h0, 32'h0, 1'b0};
        tbl[20] = '{1'b1, 32'h10, 32'h0, 32'h0, 1'b0};
        bus.req = '0;
        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;
        check("reset irq", {31'd0, irq}, 32'd0);
        check("reset alarm", {31'd0, alarm}, 32'd0);
        check("idle pready", {31'd0, bus.resp.pready}, 32'd1);
        check("idle prdata", bus.resp.prdata, 32'd0);
        for (int i = 0; i < 21; i++) begin
            xfer(tbl[i].w, tbl[i].a, tbl[i].d, 2'b00, rd, err, rd4);
            check($sformatf("vec%0d pslverr", i), {31'd0, err}, {31'd0, tbl[i].err});
            if (!tbl[i].w) check($sformatf("vec%0d prdata", i), rd, tbl[i].exp);
        end
        rd_chk("status untouched", 32'h00, 32'h0);
        @(posedge clk); #1 fault = 2'b01;
        repeat (10) @(posedge clk);
        #1 fault = 2'b00;
        repeat (3) @(posedge clk);
        #1 check("level irq masked", {31'd0, irq}, 32'd0);
        rd_chk("level cnt0", 32'h04, 32'd1);
        rd_chk("level cnt1", 32'h08, 32'd0);
        rd_chk("level status", 32'h00, 32'h1);
        wr(32'h0C, 32'h1);
        check("irq after en", {31'd0, irq}, 32'd1);
        wr(32'h00, 32'h1);
        check("irq after w1c", {31'd0, irq}, 32'd0);
        rd_chk("status after w1c", 32'h00, 32'h0);
        wr(32'h0C, 32'h2);
        @(posedge clk); #1 fault = 2'b10;
        @(posedge clk); #1 check("irq N+1", {31'd0, irq}, 32'd0);
        fault = 2'b00;
        @(posedge clk); #1 check("irq N+2", {31'd0, irq}, 32'd1);
        wr(32'h0C, 32'h0);
        pulse(2'b10, 2);
        repeat (3) @(posedge clk);
        rd_chk("back-to-back cnt1", 32'h08, 32'd3);
        wr(32'h08, 32'hDEAD);
        rd_chk("cnt1 cleared", 32'h08, 32'd0);
        wr(32'h10, 32'd3);
        pulse(2'b10, 3);
        check("alarm at cnt 2", {31'd0, alarm}, 32'd0);
        @(posedge clk); #1 check("alarm at cnt 3", {31'd0, alarm}, 32'd0);
        @(posedge clk); #1 check("alarm one later", {31'd0, alarm}, 32'd1);
        rd_chk("alarm cnt1", 32'h08, 32'd3);
        rd_chk("alarm status", 32'h00, 32'h6);
        wr(32'h00, 32'h4);
        check("alarm holds after w1c", {31'd0, alarm}, 32'd1);
        wr(32'h08, 32'h0);
        wr(32'h00, 32'h4);
        check("alarm cleared", {31'd0, alarm}, 32'd0);
        rd_chk("status after alarm clr", 32'h00, 32'h2);
        wr(32'h10, 32'd0);
        xfer(1'b1, 32'h00, 32'h1, 2'b01, rd, err, rd4);
        rd_chk("w1c vs event", 32'h00, 32'h3);
        xfer(1'b1, 32'h04, 32'h0, 2'b01, rd, err, rd4);
        rd_chk("cnt write vs event", 32'h04, 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1 fault4 = 2'b01;
            @(posedge clk); #1 fault4 = 2'b00;
        end
        repeat (3) @(posedge clk);
        xfer(1'b0, 32'h04, 32'h0, 2'b00, rd, err, rd4);
        check("sat cnt0 w4", rd4, 32'd15);
        check("main cnt0 unaffected", rd, 32'd1);
        wr(32'h10, 32'd1);
        wr(32'h0C, 32'h7);
        pulse(2'b01, 1);
        repeat (3) @(posedge clk);
        #1 check("pre-reset alarm", {31'd0, alarm}, 32'd1);
        check("pre-reset irq", {31'd0, irq}, 32'd1);
        @(posedge clk); #1 fault = 2'b11;
        bus.req = '{paddr: 32'h04, pwdata: 32'h0, pwrite: 1'b0, psel: 1'b1, penable: 1'b1, pstrb: 4'hF};
        #2 rst_ni = 1'b0;
        #1 check("rst irq", {31'd0, irq}, 32'd0);
        check("rst alarm", {31'd0, alarm}, 32'd0);
        check("rst prdata", bus.resp.prdata, 32'd0);
        check("rst pslverr", {31'd0, bus.resp.pslverr}, 32'd0);
        check("rst pready", {31'd0, bus.resp.pready}, 32'd1);
        bus.req = '0;
        fault = 2'b00;
        @(posedge clk); #1 rst_ni = 1'b1;
        rd_chk("post-rst cnt0", 32'h04, 32'd0);
        rd_chk("post-rst thresh", 32'h10, 32'd0);
        rd_chk("post-rst irq_en", 32'h0C, 32'd0);
        rd_chk("post-rst status", 32'h00, 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
